// File: rtl/count_window_monitor.sv
// Classifies sampled counter values against [LOW, HIGH], debounces region changes
// over CONFIRM agreeing samples, and reports entry/exit/wrap pulses, an entry tally and a skip flag.
module count_window_monitor #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LOW     = 1000,
  parameter int unsigned HIGH    = 50000,
  parameter int unsigned CONFIRM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] count,
  output logic [1:0]       region,
  output logic             in_range,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             wrap_pulse,
  output logic [15:0]      hit_count,
  output logic             skip_err
);

  localparam int unsigned SW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [WIDTH-1:0] LOW_W  = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] HIGH_W = WIDTH'(HIGH);

  typedef enum logic [1:0] {
    REG_BELOW  = 2'b00,
    REG_INSIDE = 2'b01,
    REG_ABOVE  = 2'b10
  } region_e;

  region_e          region_q, region_d;
  region_e          cand_q, cand_d;
  region_e          cls;
  logic [SW-1:0]    streak_q, streak_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             prev_valid_q, prev_valid_d;
  logic             in_range_q, in_range_d;
  logic             enter_q, enter_d;
  logic             exit_q, exit_d;
  logic             wrap_q, wrap_d;
  logic [15:0]      hit_q, hit_d;
  logic             skip_q, skip_d;
  logic             commit;

  // With LOW > HIGH the below/above tests cover every value, so inside never occurs.
  always_comb begin
    if (count < LOW_W) begin
      cls = REG_BELOW;
    end else if (count <= HIGH_W) begin
      cls = REG_INSIDE;
    end else begin
      cls = REG_ABOVE;
    end
  end

  always_comb begin
    region_d     = region_q;
    cand_d       = cand_q;
    streak_d     = streak_q;
    prev_count_d = prev_count_q;
    prev_valid_d = prev_valid_q;
    in_range_d   = in_range_q;
    enter_d      = 1'b0;
    exit_d       = 1'b0;
    wrap_d       = 1'b0;
    hit_d        = hit_q;
    skip_d       = skip_q;
    commit       = 1'b0;

    if (sample_valid) begin
      prev_count_d = count;
      prev_valid_d = 1'b1;
      wrap_d       = prev_valid_q && (count < prev_count_q);

      if (cls == region_q) begin
        streak_d = '0;
        cand_d   = region_q;
      end else if (cls == cand_q) begin
        if ((streak_q + 1'b1) == SW'(CONFIRM)) begin
          commit = 1'b1;
        end else begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        cand_d   = cls;
        streak_d = SW'(1);
        if (CONFIRM == 1) begin
          commit = 1'b1;
        end
      end

      // A commit always moves to a region different from the current one.
      if (commit) begin
        region_d   = cls;
        cand_d     = cls;
        streak_d   = '0;
        in_range_d = (cls == REG_INSIDE);
        enter_d    = (cls == REG_INSIDE);
        exit_d     = (region_q == REG_INSIDE);
        if ((region_q != REG_INSIDE) && (cls != REG_INSIDE)) begin
          skip_d = 1'b1;
        end
        if ((cls == REG_INSIDE) && (hit_q != '1)) begin
          hit_d = hit_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      region_q     <= REG_BELOW;
      cand_q       <= REG_BELOW;
      streak_q     <= '0;
      prev_count_q <= '0;
      prev_valid_q <= 1'b0;
      in_range_q   <= 1'b0;
      enter_q      <= 1'b0;
      exit_q       <= 1'b0;
      wrap_q       <= 1'b0;
      hit_q        <= '0;
      skip_q       <= 1'b0;
    end else begin
      region_q     <= region_d;
      cand_q       <= cand_d;
      streak_q     <= streak_d;
      prev_count_q <= prev_count_d;
      prev_valid_q <= prev_valid_d;
      in_range_q   <= in_range_d;
      enter_q      <= enter_d;
      exit_q       <= exit_d;
      wrap_q       <= wrap_d;
      hit_q        <= hit_d;
      skip_q       <= skip_d;
    end
  end

  assign region      = region_q;
  assign in_range    = in_range_q;
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign wrap_pulse  = wrap_q;
  assign hit_count   = hit_q;
  assign skip_err    = skip_q;

endmodule

// File: tb/tb_count_window_monitor.sv
// Bench for count_window_monitor: directed vector table followed by randomized
// stimulus checked against a sample-history reference model.
module tb_count_window_monitor;

  localparam int LOW     = 1000;
  localparam int HIGH    = 50000;
  localparam int CONFIRM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] count;
  logic [1:0]  region;
  logic        in_range, enter_pulse, exit_pulse, wrap_pulse, skip_err;
  logic [15:0] hit_count;

  count_window_monitor #(
    .WIDTH   (16),
    .LOW     (LOW),
    .HIGH    (HIGH),
    .CONFIRM (CONFIRM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .count        (count),
    .region       (region),
    .in_range     (in_range),
    .enter_pulse  (enter_pulse),
    .exit_pulse   (exit_pulse),
    .wrap_pulse   (wrap_pulse),
    .hit_count    (hit_count),
    .skip_err     (skip_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit r;
    bit v;
    int c;
    int e_region;
    bit e_enter;
    bit e_exit;
    bit e_wrap;
    int e_hit;
    bit e_skip;
  } vec_t;

  vec_t vq[$];

  // Reference model: region changes when the last CONFIRM valid samples since
  // reset all share one class that differs from the confirmed region.
  int m_region, m_hit, m_prev;
  bit m_enter, m_exit, m_wrap, m_skip;
  int hist[$];

  function automatic int classify(int c);
    if (c < LOW) return 0;
    if (c <= HIGH) return 1;
    return 2;
  endfunction

  function automatic void model_update(bit r, bit v, int c);
    int  cls;
    bit  agree;
    m_enter = 0;
    m_exit  = 0;
    m_wrap  = 0;
    if (r) begin
      m_region = 0;
      m_hit    = 0;
      m_skip   = 0;
      m_prev   = -1;
      hist.delete();
      return;
    end
    if (!v) return;
    cls    = classify(c);
    m_wrap = (m_prev >= 0) && (c < m_prev);
    m_prev = c;
    hist.push_back(cls);
    if (hist.size() > CONFIRM) void'(hist.pop_front());
    agree = (hist.size() == CONFIRM);
    foreach (hist[i]) if (hist[i] != cls) agree = 0;
    if (agree && cls != m_region) begin
      m_enter = (cls == 1);
      m_exit  = (m_region == 1);
      if (m_region != 1 && cls != 1) m_skip = 1;
      if (cls == 1 && m_hit < 65535) m_hit++;
      m_region = cls;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(bit r, bit v, int c);
    rst          = r;
    sample_valid = v;
    count        = c[15:0];
    @(posedge clk);
    #1;
    model_update(r, v, c);
  endtask

  task automatic check_all(string tag, int e_region, bit e_enter, bit e_exit,
                           bit e_wrap, int e_hit, bit e_skip);
    chk({tag, ".region"},   int'(region),      e_region);
    chk({tag, ".in_range"}, int'(in_range),    int'(e_region == 1));
    chk({tag, ".enter"},    int'(enter_pulse), int'(e_enter));
    chk({tag, ".exit"},     int'(exit_pulse),  int'(e_exit));
    chk({tag, ".wrap"},     int'(wrap_pulse),  int'(e_wrap));
    chk({tag, ".hit"},      int'(hit_count),   e_hit);
    chk({tag, ".skip"},     int'(skip_err),    int'(e_skip));
  endtask

  function automatic void add(bit r, bit v, int c, int rg, bit en, bit ex,
                              bit wr, int hit, bit sk);
    vec_t t;
    t = '{r, v, c, rg, en, ex, wr, hit, sk};
    vq.push_back(t);
  endfunction

  initial begin
    int mode;
    int c;
    bit v, r;

    rst = 1'b1;
    sample_valid = 1'b0;
    count = '0;

    // reset held with valid samples presented
    for (int i = 0; i < 5; i++) add(1, 1, 2000, 0, 0, 0, 0, 0, 0);
    // ramp into the window
    for (int c0 = 997; c0 <= 1002; c0++) add(0, 1, c0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1003, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1004, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1005, 1, 0, 0, 0, 1, 0);
    // glitch breaks the streak (999 also wraps)
    add(1, 0, 0,    0, 0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1001, 0, 0, 0, 0, 0, 0);
    add(0, 1, 999,  0, 0, 0, 1, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1001, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1002, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1003, 1, 1, 0, 0, 1, 0);
    // upper bound
    add(0, 1, 50000, 1, 0, 0, 0, 1, 0);
    add(0, 1, 50001, 1, 0, 0, 0, 1, 0);
    add(0, 1, 50002, 1, 0, 0, 0, 1, 0);
    add(0, 1, 50003, 1, 0, 0, 0, 1, 0);
    add(0, 1, 50004, 2, 0, 1, 0, 1, 0);
    // wrap
    add(0, 1, 65534, 2, 0, 0, 0, 1, 0);
    add(0, 1, 65535, 2, 0, 0, 0, 1, 0);
    add(0, 1, 0,     2, 0, 0, 1, 1, 0);
    add(0, 1, 5,     2, 0, 0, 0, 1, 0);
    // below -> above skip
    add(1, 0, 0,     0, 0, 0, 0, 0, 0);
    add(0, 1, 500,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 60000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 60000, 2, 0, 0, 0, 0, 1);
    add(0, 1, 60000, 2, 0, 0, 0, 0, 1);
    // gaps keep the streak
    add(1, 0, 0,    0, 0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1001, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 7, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1002, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1003, 1, 1, 0, 0, 1, 0);
    add(0, 0, 1003, 1, 0, 0, 0, 1, 0);
    // mid-operation reset discards the streak
    add(1, 0, 0,    0, 0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1001, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1002, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0,    0, 0, 0, 0, 0, 0);
    add(0, 1, 1003, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1004, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1005, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1006, 1, 1, 0, 0, 1, 0);
    // exit and wrap on the same sample
    for (int i = 0; i < 3; i++) add(0, 1, 60000, 1, 0, 0, 0, 1, 0);
    add(0, 1, 50001, 2, 0, 1, 1, 1, 0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].v, vq[i].c);
      check_all($sformatf("vec%0d", i), vq[i].e_region, vq[i].e_enter,
                vq[i].e_exit, vq[i].e_wrap, vq[i].e_hit, vq[i].e_skip);
    end

    mode = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 3);
      case (mode)
        0: c = $urandom_range(0, LOW - 1);
        1: c = $urandom_range(LOW, HIGH);
        2: c = $urandom_range(HIGH + 1, 65535);
        default: begin
          case ($urandom_range(0, 3))
            0: c = LOW - 1;
            1: c = LOW;
            2: c = HIGH;
            default: c = HIGH + 1;
          endcase
        end
      endcase
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, c);
      check_all("rand", m_region, m_enter, m_exit, m_wrap, m_hit, m_skip);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
